// File: rtl/hack_loader_pkg.sv
// Shared constants for the hack_loader boot-image loader: state encodings,
// wire field sizes and byte order of multi-byte fields.
package hack_loader_pkg;

  localparam int BYTE_W    = 8;
  localparam int LEN_BYTES = 2;
  localparam int LEN_W     = LEN_BYTES * BYTE_W;
  localparam int CHK_BYTES = 2;
  localparam int CHK_W     = CHK_BYTES * BYTE_W;

  // Every multi-byte field on the link is sent most significant byte first.
  localparam bit BIG_ENDIAN = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN_HI  = 3'd1;
  localparam logic [2:0] ST_LEN_LO  = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DATA_LO = 3'd4;
  localparam logic [2:0] ST_FINISH  = 3'd5;
`ifdef HACK_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK_HI  = 3'd6;
  localparam logic [2:0] ST_CHK_LO  = 3'd7;
`endif

  function automatic logic [LEN_W-1:0] join_bytes(input logic [BYTE_W-1:0] first,
                                                  input logic [BYTE_W-1:0] second);
    return BIG_ENDIAN ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/hack_loader_word_asm.sv
// Byte-pair assembly for hack_loader: high-byte latch, word register and,
// when HACK_LOADER_CHECKSUM_EN is defined, the running word-sum accumulator.
module hack_loader_word_asm
  import hack_loader_pkg::*;
(
  input  logic              i_CLK,
  input  logic              i_Reset,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_hi_load,
  input  logic              i_word_load,
`ifdef HACK_LOADER_CHECKSUM_EN
  input  logic              i_sum_clear,
  output logic              o_sum_match,
`endif
  output logic [BYTE_W-1:0] o_hi,
  output logic [LEN_W-1:0]  o_word
);

  logic [BYTE_W-1:0] hi_q;
  logic [LEN_W-1:0]  pair;

  assign pair = join_bytes(hi_q, i_byte);
  assign o_hi = hi_q;

  // Pure data latch: only read after a load in the same session.
  always_ff @(posedge i_CLK) begin
    if (i_hi_load) hi_q <= i_byte;
  end

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset)          o_word <= '0;
    else if (i_word_load) o_word <= pair;
  end

`ifdef HACK_LOADER_CHECKSUM_EN
  logic [CHK_W-1:0] sum_q;

  always_ff @(posedge i_CLK) begin
    if (i_sum_clear)      sum_q <= '0;
    else if (i_word_load) sum_q <= sum_q + pair;
  end

  // Valid while the low checksum byte sits on i_byte and hi_q holds the high one.
  assign o_sum_match = (pair == sum_q);
`endif

endmodule

// File: rtl/hack_loader.sv
// hack_loader: receives a length-prefixed big-endian word image over a byte
// link and writes it to memory from address 0. Optional HACK_LOADER_CHECKSUM_EN.
module hack_loader
  import hack_loader_pkg::*;
#(
  parameter int DEPTH = 2**14,
  parameter int WIDTH = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_Reset,
  input  logic                     i_Start,
  input  logic [7:0]               i_Byte,
  input  logic                     i_Byte_Valid,
  output logic                     o_Byte_Ready,
  output logic [WIDTH-1:0]         o_Mem_Data,
  output logic [$clog2(DEPTH)-1:0] o_Mem_Address,
  output logic                     o_Mem_Write_EN,
  output logic                     o_Busy,
  output logic                     o_Done,
  output logic                     o_Error
);

  localparam int AW = $clog2(DEPTH);

`ifdef HACK_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_CHK_HI;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_FINISH;
`endif

  logic [2:0]       state;
  logic [LEN_W-1:0] word_idx;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] len_field;
  logic [7:0]       hi_byte;
  logic             accept;
  logic             hi_load;
  logic             word_load;

  always_comb begin
    o_Byte_Ready = 1'b0;
    case (state)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: o_Byte_Ready = 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
      ST_CHK_HI, ST_CHK_LO:                         o_Byte_Ready = 1'b1;
`endif
      default:                                      o_Byte_Ready = 1'b0;
    endcase
  end

  assign o_Busy    = (state != ST_IDLE) && (state != ST_FINISH);
  assign o_Done    = (state == ST_FINISH);
  assign accept    = i_Byte_Valid && o_Byte_Ready;
  assign word_load = accept && (state == ST_DATA_LO);
`ifdef HACK_LOADER_CHECKSUM_EN
  assign hi_load   = accept && ((state == ST_LEN_HI) || (state == ST_DATA_HI) ||
                                (state == ST_CHK_HI));
`else
  assign hi_load   = accept && ((state == ST_LEN_HI) || (state == ST_DATA_HI));
`endif
  assign len_field = join_bytes(hi_byte, i_Byte);

`ifdef HACK_LOADER_CHECKSUM_EN
  logic sum_match;
`endif

  hack_loader_word_asm u_word_asm (
    .i_CLK       (i_CLK),
    .i_Reset     (i_Reset),
    .i_byte      (i_Byte),
    .i_hi_load   (hi_load),
    .i_word_load (word_load),
`ifdef HACK_LOADER_CHECKSUM_EN
    .i_sum_clear (state == ST_IDLE),
    .o_sum_match (sum_match),
`endif
    .o_hi        (hi_byte),
    .o_word      (o_Mem_Data)
  );

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      state          <= ST_IDLE;
      word_idx       <= '0;
      last_idx       <= '0;
      o_Mem_Address  <= '0;
      o_Mem_Write_EN <= 1'b0;
      o_Error        <= 1'b0;
    end else begin
      o_Mem_Write_EN <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_Start) begin
            state    <= ST_LEN_HI;
            word_idx <= '0;
            o_Error  <= 1'b0;
          end
        end
        ST_LEN_HI: if (accept) state <= ST_LEN_LO;
        ST_LEN_LO: begin
          if (accept) begin
            last_idx <= len_field - 1'b1;
            if (len_field == '0) begin
              state <= ST_AFTER_DATA;
            end else if (int'(len_field) > DEPTH) begin
              // Image would overrun memory: reject before any write.
              state   <= ST_FINISH;
              o_Error <= 1'b1;
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: if (accept) state <= ST_DATA_LO;
        ST_DATA_LO: begin
          if (accept) begin
            o_Mem_Write_EN <= 1'b1;
            o_Mem_Address  <= AW'(word_idx);
            word_idx       <= word_idx + 1'b1;
            state          <= (word_idx == last_idx) ? ST_AFTER_DATA : ST_DATA_HI;
          end
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        ST_CHK_HI: if (accept) state <= ST_CHK_LO;
        ST_CHK_LO: begin
          if (accept) begin
            state <= ST_FINISH;
            if (!sum_match) o_Error <= 1'b1;
          end
        end
`endif
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_loader.sv
// Self-checking bench for hack_loader (DEPTH=16): directed sessions plus
// randomized images with stalls and stray Start pulses. Honours HACK_LOADER_CHECKSUM_EN.
module tb_hack_loader;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          i_Reset;
  logic          i_Start;
  logic [7:0]    i_Byte;
  logic          i_Byte_Valid;
  logic          o_Byte_Ready;
  logic [15:0]   o_Mem_Data;
  logic [AW-1:0] o_Mem_Address;
  logic          o_Mem_Write_EN;
  logic          o_Busy;
  logic          o_Done;
  logic          o_Error;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_wr = 0;
  bit have_prev = 0;
  logic [15:0] wr_data_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0] shadow[DEPTH];
  logic [15:0] wbuf[32];
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [15:0] chk_delta = 16'h0;
`endif

  hack_loader #(.DEPTH(DEPTH), .WIDTH(16)) dut (
    .i_CLK          (clk),
    .i_Reset        (i_Reset),
    .i_Start        (i_Start),
    .i_Byte         (i_Byte),
    .i_Byte_Valid   (i_Byte_Valid),
    .o_Byte_Ready   (o_Byte_Ready),
    .o_Mem_Data     (o_Mem_Data),
    .o_Mem_Address  (o_Mem_Address),
    .o_Mem_Write_EN (o_Mem_Write_EN),
    .o_Busy         (o_Busy),
    .o_Done         (o_Done),
    .o_Error        (o_Error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory-side monitor: models the memory and the strobe spacing rule.
  always @(negedge clk) begin
    if (o_Done) done_cnt++;
    if (o_Mem_Write_EN) begin
      if (have_prev) check("wr_spacing_ge2", 32'(cyc - last_wr >= 2), 1);
      last_wr   = cyc;
      have_prev = 1;
      wr_addr_q.push_back(o_Mem_Address);
      wr_data_q.push_back(o_Mem_Data);
      shadow[o_Mem_Address] = o_Mem_Data;
    end
  end

  // Entered and left at posedge+1; optional idle gaps with stray Start pulses.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit mid);
    int t = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        i_Byte_Valid = 1'b0;
        i_Byte       = 8'($urandom);
        i_Start      = mid && ($urandom_range(0, 2) == 0);
        @(posedge clk); #1;
        i_Start      = 1'b0;
      end
    end
    i_Byte       = b;
    i_Byte_Valid = 1'b1;
    while (!o_Byte_Ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_wait", o_Byte_Ready, 1);
    @(posedge clk); #1;
    i_Byte_Valid = 1'b0;
  endtask

  task automatic run_session(input int n, input bit gaps, input bit mid);
    bit          oversize = (n > DEPTH);
    bit          exp_err;
    logic [15:0] len = 16'(n);
    logic [15:0] sum = 16'h0;
    int          d0;
    wr_addr_q.delete();
    wr_data_q.delete();
    d0 = done_cnt;
    i_Start = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0;
    check("start_busy", o_Busy, 1);
    check("start_ready", o_Byte_Ready, 1);
    check("start_err_clr", o_Error, 0);
    send_byte(len[15:8], gaps, mid);
    send_byte(len[7:0], gaps, mid);
    exp_err = oversize;
    if (!oversize) begin
      for (int k = 0; k < n; k++) begin
        send_byte(wbuf[k][15:8], gaps, mid);
        send_byte(wbuf[k][7:0], gaps, mid);
        sum = sum + wbuf[k];
      end
`ifdef HACK_LOADER_CHECKSUM_EN
      sum = sum + chk_delta;
      send_byte(sum[15:8], gaps, mid);
      send_byte(sum[7:0], gaps, mid);
      exp_err = (chk_delta != 16'h0);
`endif
    end
    check("finish_done", o_Done, 1);
    check("finish_busy", o_Busy, 0);
    check("finish_ready", o_Byte_Ready, 0);
    check("finish_error", o_Error, 32'(exp_err));
    @(posedge clk); #1;
    check("done_one_cycle", o_Done, 0);
    check("error_held", o_Error, 32'(exp_err));
    check("done_count", done_cnt, d0 + 1);
    check("write_count", wr_addr_q.size(), oversize ? 0 : n);
    for (int k = 0; k < wr_addr_q.size() && k < n; k++) begin
      check("write_addr", 32'(wr_addr_q[k]), k);
      check("write_data", 32'(wr_data_q[k]), 32'(wbuf[k]));
    end
  endtask

  initial begin
    int d0;
    i_Reset = 1'b1; i_Start = 1'b0; i_Byte = 8'h0; i_Byte_Valid = 1'b0;
    for (int a = 0; a < DEPTH; a++) shadow[a] = 16'h0;
    #1;
    check("reset_outputs", {o_Byte_Ready, o_Busy, o_Done, o_Error, o_Mem_Write_EN,
                            o_Mem_Address, o_Mem_Data}, 0);
    @(negedge clk); i_Reset = 1'b0;
    @(posedge clk); #1;

    // Bytes offered in IDLE are refused.
    i_Byte = 8'h55; i_Byte_Valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ready", o_Byte_Ready, 0);
      check("idle_busy", o_Busy, 0);
    end
    i_Byte_Valid = 1'b0;

    // Basic two-word load.
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    run_session(2, 0, 0);

    // Zero length.
    run_session(0, 0, 0);

    // Oversize length, error sticky until next Start.
    run_session(17, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("error_sticky", o_Error, 1);
    end

    // Full-depth image boundary.
    for (int k = 0; k < DEPTH; k++) wbuf[k] = 16'($urandom);
    run_session(DEPTH, 0, 0);

    // Reset after the first word of a session.
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    wr_addr_q.delete(); wr_data_q.delete();
    i_Start = 1'b1; @(posedge clk); #1; i_Start = 1'b0;
    send_byte(8'h00, 0, 0); send_byte(8'h02, 0, 0);
    send_byte(8'h12, 0, 0); send_byte(8'h34, 0, 0);
    d0 = done_cnt;
    @(negedge clk); #2;
    i_Reset = 1'b1;
    #1;
    check("rst_mid_outputs", {o_Byte_Ready, o_Busy, o_Done, o_Error, o_Mem_Write_EN,
                              o_Mem_Address, o_Mem_Data}, 0);
    check("rst_mid_mem0", 32'(shadow[0]), 32'h1234);
    repeat (2) @(posedge clk);
    @(negedge clk); i_Reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_no_done", done_cnt, d0);
    for (int k = 0; k < 3; k++) wbuf[k] = 16'($urandom);
    run_session(3, 1, 0);

    // Randomized images with stalls and stray Start pulses.
    for (int s = 0; s < 8; s++) begin
      int n = $urandom_range(0, DEPTH + 2);
      for (int k = 0; k < n && k < 32; k++) wbuf[k] = 16'($urandom);
      run_session(n, 1, 1);
    end

`ifdef HACK_LOADER_CHECKSUM_EN
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    chk_delta = 16'h0;
    run_session(2, 0, 0);
    chk_delta = 16'h1;
    run_session(2, 0, 0);
    chk_delta = 16'h0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
